// File: rtl/mul4bit_seq_if.sv
// mul4bit_seq_if: request operands and registered result/handshake for mul4bit_seq.
interface mul4bit_seq_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] R;
    logic [7:0] Product;
    logic       Overflow;
    logic       Busy;
    logic       Done;
    modport master (output start, A, B, R, input Product, Overflow, Busy, Done);
    modport slave  (input start, A, B, R, output Product, Overflow, Busy, Done);
endinterface

// File: rtl/mul4bit_seq.sv
// mul4bit_seq: 4x4 shift-and-add multiplier, 4 steps per operation.
// Define RECON_ADD_EN to seed the accumulator with R (Product = A*B + R).
module mul4bit_seq (
    input logic          clk,
    input logic          rst,
    mul4bit_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t     state, state_nx;
    logic [7:0] acc, acc_nx, init;
    logic [3:0] a_l, b_l;
    logic [1:0] count;
`ifdef RECON_ADD_EN
    assign init = {4'b0, bus.R};
`else
    assign init = 8'h00;
`endif
    assign bus.Busy = state == CALC;
    assign bus.Done = state == DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE && bus.start) state_nx = CALC;
        else if (state == CALC && count == 2'd3) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
        acc_nx = acc + (b_l[count] ? ({4'b0, a_l} << count) : 8'h00);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            acc          <= 8'h00;
            count        <= 2'd0;
            a_l          <= 4'h0;
            b_l          <= 4'h0;
            bus.Product  <= 8'h00;
            bus.Overflow <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_l   <= bus.A;
            b_l   <= bus.B;
            acc   <= init;
            count <= 2'd0;
        end else if (state == CALC) begin
            acc   <= acc_nx;
            count <= count + 2'd1;
            if (count == 2'd3) begin
                bus.Product  <= acc_nx;
                bus.Overflow <= |acc_nx[7:4];
            end
        end
endmodule

// File: tb/tb_mul4bit_seq.sv
// tb_mul4bit_seq: directed vectors for mul4bit_seq; expectations follow RECON_ADD_EN.
module tb_mul4bit_seq;
`ifdef RECON_ADD_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif
    logic clk, rst;
    int   checks = 0, errors = 0;
    mul4bit_seq_if bus ();
    mul4bit_seq dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // Starts at the current negedge; operands are scrambled right after acceptance and,
    // with poke set, start is held high through CALC and DONE to show it is ignored.
    task automatic run(input logic [3:0] a, b, r, input logic [7:0] ep, input logic eo, input bit poke);
        bus.A = a; bus.B = b; bus.R = r; bus.start = 1'b1;
        @(negedge clk);
        bus.start = poke;
        bus.A = ~a; bus.B = ~b; bus.R = ~r;
        repeat (4) begin
            chk("busy_calc", {7'b0, bus.Busy}, 8'd1);
            chk("done_calc", {7'b0, bus.Done}, 8'd0);
            @(negedge clk);
        end
        chk("done_pulse", {7'b0, bus.Done}, 8'd1);
        chk("busy_done", {7'b0, bus.Busy}, 8'd0);
        chk("product", bus.Product, ep);
        chk("overflow", {7'b0, bus.Overflow}, {7'b0, eo});
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_single", {7'b0, bus.Done}, 8'd0);
        chk("busy_idle", {7'b0, bus.Busy}, 8'd0);
        chk("product_hold", bus.Product, ep);
    endtask
    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.A = 4'h0; bus.B = 4'h0; bus.R = 4'h0;
        @(negedge clk);
        chk("rst_product", bus.Product, 8'h00);
        chk("rst_overflow", {7'b0, bus.Overflow}, 8'd0);
        chk("rst_busy", {7'b0, bus.Busy}, 8'd0);
        chk("rst_done", {7'b0, bus.Done}, 8'd0);
        rst = 1'b0;
        run(4'd7, 4'd3, 4'd0, 8'h15, 1'b1, 1'b0);
        run(4'd2, 4'd5, 4'd3, ADD ? 8'h0D : 8'h0A, 1'b0, 1'b0);
        run(4'd15, 4'd15, 4'd15, ADD ? 8'hF0 : 8'hE1, 1'b1, 1'b0);
        run(4'd9, 4'd0, 4'd6, ADD ? 8'h06 : 8'h00, 1'b0, 1'b0);
        run(4'd0, 4'd9, 4'd5, ADD ? 8'h05 : 8'h00, 1'b0, 1'b0);
        run(4'd3, 4'd3, 4'd1, ADD ? 8'h0A : 8'h09, 1'b0, 1'b1);
        run(4'd1, 4'd8, 4'd7, ADD ? 8'h0F : 8'h08, 1'b0, 1'b0);
        run(4'd3, 4'd5, 4'd2, ADD ? 8'h11 : 8'h0F, ADD, 1'b0);
        bus.A = 4'd5; bus.B = 4'd5; bus.R = 4'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {7'b0, bus.Busy}, 8'd0);
        chk("abort_done", {7'b0, bus.Done}, 8'd0);
        chk("abort_product", bus.Product, 8'h00);
        chk("abort_overflow", {7'b0, bus.Overflow}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", {7'b0, bus.Done}, 8'd0);
            chk("abort_idle", {7'b0, bus.Busy}, 8'd0);
        end
        run(4'd4, 4'd4, 4'd0, 8'h10, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
